// File: rtl/page_reg_sched.sv
// page_reg_sched: round-robin arbiter/sequencer for a shared registered-read paged bank; define PAGE_SCHED_FIXED_PRI_EN for fixed lowest-index priority
module page_reg_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*AW-1:0]    addr,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rdata,
   output logic [AW-1:0]         bank_sel,
   output logic [WIDTH-1:0]      bank_din,
   output logic                  bank_en_in,
   output logic                  bank_en_out,
   input  logic [WIDTH-1:0]      bank_dout
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
   logic found, we_q, we_d, en_in_q, en_in_d, en_out_q, en_out_d;
   logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
   logic [WIDTH-1:0] rdata_q, rdata_d, din_q, din_d;
   logic [AW-1:0] sel_q, sel_d;
   // first requester at or above ptr, wrapping; ptr is held at 0 in the fixed-priority build
   always_comb begin
      pick = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            pick = PW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end
   // transaction sequencing; every output is computed one cycle ahead and registered
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      win_d = win_q;
      we_d = we_q;
      gnt_d = gnt_q;
      ack_d = '0;
      rdata_d = rdata_q;
      sel_d = sel_q;
      din_d = din_q;
      en_in_d = 1'b0;
      en_out_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ACCESS;
               win_d = pick;
               we_d = we[pick];
               gnt_d = '0;
               gnt_d[pick] = 1'b1;
               sel_d = addr[int'(pick)*AW +: AW];
               din_d = we[pick] ? wdata[int'(pick)*WIDTH +: WIDTH] : din_q;
               en_in_d = we[pick];
               en_out_d = !we[pick];
            end
         end
         ACCESS: begin
            state_d = we_q ? DONE : RWAIT;
            ack_d[win_q] = we_q;
         end
         RWAIT: begin
            state_d = DONE;
            rdata_d = bank_dout;
            ack_d[win_q] = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            gnt_d = '0;
`ifdef PAGE_SCHED_FIXED_PRI_EN
            ptr_d = '0;
`else
            ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset discards any in-flight transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q <= '0;
         win_q <= '0;
         we_q <= 1'b0;
         gnt_q <= '0;
         ack_q <= '0;
         rdata_q <= '0;
         sel_q <= '0;
         din_q <= '0;
         en_in_q <= 1'b0;
         en_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         we_q <= we_d;
         gnt_q <= gnt_d;
         ack_q <= ack_d;
         rdata_q <= rdata_d;
         sel_q <= sel_d;
         din_q <= din_d;
         en_in_q <= en_in_d;
         en_out_q <= en_out_d;
      end
   end
   assign gnt = gnt_q;
   assign ack = ack_q;
   assign rdata = rdata_q;
   assign bank_sel = sel_q;
   assign bank_din = din_q;
   assign bank_en_in = en_in_q;
   assign bank_en_out = en_out_q;
endmodule
